// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory side of the datapath MFA/MOC handshake. Holds a big-endian byte
//   array of 2^ADDR_BITS bytes and answers each request with MOC after a
//   fixed wait of LATENCY cycles. Supports byte, halfword, word, signed
//   byte/halfword and a two-beat doubleword. Misaligned or reserved-size
//   requests are answered with ALIGN_ERR and never touch the array.
//
// Ports
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset (array contents kept)
//   MFA        memory function activate (request valid, held until MOC seen)
//   RW         1 = read, 0 = write
//   DS[2:0]    000 B, 001 H, 010 W, 011 DW, 100 SB, 101 SH, 11x reserved
//   ADDR[31:0] byte address, only [ADDR_BITS-1:0] used
//   DATA_IN    right-justified write data
//   DATA_OUT   read data, valid while MOC = 1
//   MOC        memory operation complete
//   BUSY       high whenever the FSM is not idle
//   ALIGN_ERR  qualifies MOC: request was rejected
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MFA,
    input  logic        RW,
    input  logic [2:0]  DS,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        MOC,
    output logic        BUSY,
    output logic        ALIGN_ERR
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
    // WAIT2 runs LATENCY-1 cycles, the ACK1 cycle already counted as one
    localparam logic [3:0] CNT_INIT2 = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef logic [ADDR_BITS-1:0] addr_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ACK1  = 3'd2,
        S_WAIT2 = 3'd3,
        S_ACK   = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    function automatic logic f_misaligned(input logic [2:0] ds, input addr_t a);
        case (ds)
            3'b000, 3'b100: f_misaligned = 1'b0;
            3'b001, 3'b101: f_misaligned = a[0];
            3'b010:         f_misaligned = |a[1:0];
            3'b011:         f_misaligned = |a[2:0];
            default:        f_misaligned = 1'b1;
        endcase
    endfunction

    logic [7:0]  r_mem [DEPTH];

    state_t      r_state;
    logic        r_rw;
    logic [2:0]  r_ds;
    addr_t       r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [3:0]  r_cnt;
    logic [31:0] r_dout;

    state_t      w_next;
    logic [3:0]  w_cnt_next;
    logic        w_enter;      // this edge enters ACK/ACK1: commit point
    logic        w_cur_rw;
    logic [2:0]  w_cur_ds;
    addr_t       w_cur_a;
    logic [31:0] w_cur_d;
    logic        w_cur_err;
    logic        w_we;
    addr_t       w_a1, w_a2, w_a3;
    logic [7:0]  w_b0, w_b1, w_b2, w_b3;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused = ^ADDR[31:ADDR_BITS];

    // The access parameters come from the inputs when committing straight out
    // of IDLE (LATENCY = 1), from the latched copy otherwise; the second
    // doubleword beat uses addr+4 and the freshly re-latched DATA_IN.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_enter    = 1'b0;
        w_cur_rw   = r_rw;
        w_cur_ds   = r_ds;
        w_cur_a    = r_addr;
        w_cur_d    = r_wdata;
        w_cur_err  = r_err;
        case (r_state)
            S_IDLE: begin
                w_cur_rw  = RW;
                w_cur_ds  = DS;
                w_cur_a   = ADDR[ADDR_BITS-1:0];
                w_cur_d   = DATA_IN;
                w_cur_err = f_misaligned(DS, ADDR[ADDR_BITS-1:0]);
                if (MFA) begin
                    if (LATENCY == 1) begin
                        w_enter = 1'b1;
                        w_next  = (DS == 3'b011 && !w_cur_err) ? S_ACK1 : S_ACK;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!MFA) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_enter = 1'b1;
                    w_next  = (r_ds == 3'b011 && !r_err) ? S_ACK1 : S_ACK;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_ACK1: begin
                w_cur_a = r_addr + addr_t'(4);
                w_cur_d = DATA_IN;
                if (LATENCY == 1) begin
                    w_enter = 1'b1;
                    w_next  = S_ACK;
                end else begin
                    w_next     = S_WAIT2;
                    w_cnt_next = CNT_INIT2;
                end
            end
            S_WAIT2: begin
                if (!MFA) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_enter = 1'b1;
                    w_next  = S_ACK;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                if (!MFA) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;  // HOLD and illegal encodings
        endcase
    end

    assign w_a1 = w_cur_a + addr_t'(1);
    assign w_a2 = w_cur_a + addr_t'(2);
    assign w_a3 = w_cur_a + addr_t'(3);
    assign w_b0 = r_mem[w_cur_a];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        case (w_cur_ds)
            3'b000:  w_rdata = {24'd0, w_b0};
            3'b100:  w_rdata = {{24{w_b0[7]}}, w_b0};
            3'b001:  w_rdata = {16'd0, w_b0, w_b1};
            3'b101:  w_rdata = {{16{w_b0[7]}}, w_b0, w_b1};
            default: w_rdata = {w_b0, w_b1, w_b2, w_b3};
        endcase
    end

    assign w_we = w_enter && !w_cur_err && !w_cur_rw;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_rw    <= 1'b0;
            r_ds    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_cnt   <= 4'd0;
            r_dout  <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && MFA) begin
                r_rw    <= RW;
                r_ds    <= DS;
                r_addr  <= ADDR[ADDR_BITS-1:0];
                r_wdata <= DATA_IN;
                r_err   <= w_cur_err;
            end
            if (r_state == S_ACK1) begin
                r_addr  <= w_cur_a;
                r_wdata <= DATA_IN;
            end
            if (w_enter) begin
                r_dout <= (!w_cur_err && w_cur_rw) ? w_rdata : 32'd0;
            end else if (w_next == S_IDLE) begin
                r_dout <= 32'd0;
                r_err  <= 1'b0;
            end
        end
    end

    // Array is never reset; the RESET gate keeps an aborted access from
    // landing if reset and the commit edge coincide.
    always_ff @(posedge CLK) begin
        if (w_we && !RESET) begin
            case (w_cur_ds[1:0])
                2'b00: r_mem[w_cur_a] <= w_cur_d[7:0];
                2'b01: begin
                    r_mem[w_cur_a] <= w_cur_d[15:8];
                    r_mem[w_a1]    <= w_cur_d[7:0];
                end
                default: begin
                    r_mem[w_cur_a] <= w_cur_d[31:24];
                    r_mem[w_a1]    <= w_cur_d[23:16];
                    r_mem[w_a2]    <= w_cur_d[15:8];
                    r_mem[w_a3]    <= w_cur_d[7:0];
                end
            endcase
        end
    end

    assign MOC       = (r_state == S_ACK) || (r_state == S_ACK1);
    assign BUSY      = (r_state != S_IDLE);
    assign ALIGN_ERR = r_err && (r_state == S_ACK);
    assign DATA_OUT  = r_dout;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the datapath's memory handshake.
- The datapath raises MFA with address, R/W, data-size and write data. This block performs the byte-addressed access on its internal big-endian array and answers with MOC after a fixed wait.
- Supports byte, halfword, word, signed byte/halfword and two-beat doubleword. Misaligned accesses are flagged.

Parameters:
- ADDR_BITS, 8, byte-address width; array depth is 2^ADDR_BITS bytes.
- LATENCY, 2, cycles from the MFA-sampling edge to MOC assertion; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- MFA  input  1  memory function activate (request valid).
- RW  input  1  1 = read, 0 = write.
- DS  input  3  data size: 000 byte, 001 halfword, 010 word, 011 doubleword, 100 signed byte, 101 signed halfword, 11x reserved.
- ADDR  input  32  byte address; only bits [ADDR_BITS-1:0] are used.
- DATA_IN  input  32  write data, right-justified.
- DATA_OUT  output  32  read data, valid while MOC = 1.
- MOC  output  1  memory operation complete.
- BUSY  output  1  high in every state except IDLE.
- ALIGN_ERR  output  1  qualifies MOC; the access was rejected.

Behaviour:
- Reset (async, RESET = 1): state IDLE; MOC = 0, BUSY = 0, ALIGN_ERR = 0, DATA_OUT = 0. Array contents are not cleared.
- Reset mid-operation aborts the access. A write whose ACK edge has not occurred is not committed.
- States: IDLE, WAIT, ACK1, WAIT2, ACK, HOLD.
- IDLE:
  - When MFA = 1 at an edge, latch RW, DS, ADDR[ADDR_BITS-1:0] and DATA_IN.
  - Load the counter with LATENCY-1 and go to WAIT, or go directly to ACK/ACK1 if LATENCY = 1.
  - All later changes to these inputs are ignored until the next IDLE.
- WAIT: decrement the counter each cycle. At 0, go to ACK1 if DS = 011, else ACK.
- MFA abort: if MFA = 0 at any edge in WAIT or WAIT2, return to IDLE. No write, no MOC.
- Alignment check, done at latch time:
  - halfword/signed halfword need addr[0] = 0; word needs addr[1:0] = 0; doubleword needs addr[2:0] = 0; DS 11x is always an error.
  - On error, no array access. The block goes to ACK with ALIGN_ERR = 1 and DATA_OUT = 0, and ALIGN_ERR clears on return to IDLE.
- Write commit: on the edge entering ACK/ACK1.
  - byte: DATA_IN[7:0] to addr.
  - halfword: DATA_IN[15:8] to addr, [7:0] to addr+1.
  - word: bytes [31:24] to addr, [23:16] to addr+1, [15:8] to addr+2, [7:0] to addr+3 (big-endian).
- Read data: registered on the same edge.
  - byte: zero-extended.
  - signed byte: bit 7 sign-extended.
  - halfword / signed halfword: the same rules on bit 15.
  - word: {addr, addr+1, addr+2, addr+3}.
- ACK: MOC = 1 and DATA_OUT is held stable. Stay while MFA = 1. When MFA = 0 at an edge, go to IDLE with MOC = 0 at that edge. A new request needs MFA low for at least one edge.
- Doubleword:
  - ACK1 asserts MOC for exactly one cycle with word 0 (addr). For writes, word 0 comes from DATA_IN latched at request.
  - Then WAIT2 runs LATENCY-1 cycles. In WAIT2, DATA_IN is re-latched on the ACK1 edge for the second write word.
  - Then ACK with word 1 at addr+4 until MFA falls.
- Address wrap: all byte addresses are computed modulo 2^ADDR_BITS. Doubleword at 0xF8 with ADDR_BITS = 8 uses 0xF8 and 0xFC; no wrap error exists.
- HOLD is reserved and unused. Decoding it returns to IDLE, and illegal state encodings also return to IDLE.
- MOC latency, LATENCY = 2: MFA sampled at edge n gives MOC = 1 after edge n+2.

Test Plan:
- Word write 0xDEADBEEF at 0x10, then word read at 0x10 (LATENCY = 2) -> MOC rises 2 edges after MFA is sampled; DATA_OUT = 0xDEADBEEF; byte read at 0x10 = 0x000000DE; byte read at 0x13 = 0x000000EF.
- Signed byte read at 0x12 (0xBE) -> DATA_OUT = 0xFFFFFFBE. Halfword read at 0x12 -> 0x0000BEEF. Signed halfword read -> 0xFFFFBEEF.
- Word read at 0x11 -> MOC = 1 with ALIGN_ERR = 1 and DATA_OUT = 0; array unchanged. DS = 111 -> same response.
- Doubleword write 0x11111111 / 0x22222222 at 0x20, then doubleword read -> first MOC is a one-cycle pulse with 0x11111111; second MOC holds 0x22222222 until MFA drops; word read at 0x24 = 0x22222222.
- MFA dropped in WAIT during a write to 0x30 -> no MOC, return to IDLE, 0x30 unchanged. RESET pulsed in WAIT -> outputs 0 immediately, no write.
- Doubleword at 0xF8 (ADDR_BITS = 8) wraps correctly within the array. MFA held high after MOC -> MOC stays high and no second access occurs until MFA goes low for one edge.
